unified_mem_arbiter: RTL

//  Arbitrates the single unified, byte-addressable, little-endian 32-bit memory between the fetch stage (I-port) and the load/store stage (D-port).

---
 rtl/unified_mem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Shares one unified, byte-addressable, little-endian 32-bit
//            memory between the fetch port (i_*) and the load/store port
//            (d_*). Each access runs IDLE -> ACCESS -> RESP, so the memory
//            does its negedge read/write during ACCESS. Misaligned requests
//            (when CHECK_ALIGN=1) skip ACCESS and answer with done+err.
// Ports    : clk, reset (async, active-high)
//            i_req/i_addr -> i_done/i_err/i_rdata      fetch port
//            d_req/d_we/d_addr/d_wdata
//                         -> d_done/d_err/d_rdata      load/store port
//            mem_addr/mem_we/mem_wdata -> memory, mem_rdata <- memory
//            busy (state != IDLE), owner (0 = I, 1 = D, last grant)
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter bit CHECK_ALIGN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_done,
    output logic        i_err,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_done,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;
    localparam logic [3:0] c_limit     = 4'(STARVE_LIMIT);

    logic [1:0]  state_q,     state_d;
    logic        owner_q,     owner_d;
    logic        err_q,       err_d;
    logic [3:0]  starve_q,    starve_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic        mem_we_q,    mem_we_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] i_rdata_q,   i_rdata_d;
    logic [31:0] d_rdata_q,   d_rdata_d;

    logic        w_grant_i;
    logic        w_grant_d;
    logic [31:0] w_sel_addr;
    logic        w_misal;

    // D wins unless I has been passed over STARVE_LIMIT times in a row.
    assign w_grant_i  = i_req && (!d_req || (starve_q == c_limit));
    assign w_grant_d  = d_req && !w_grant_i;
    assign w_sel_addr = w_grant_i ? i_addr : d_addr;
    assign w_misal    = CHECK_ALIGN && (w_sel_addr[1:0] != 2'b00);

    // State register (all flops; async reset clears mem_we and done at once)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= c_st_idle;
            owner_q     <= 1'b0;
            err_q       <= 1'b0;
            starve_q    <= 4'd0;
            mem_addr_q  <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 32'd0;
            i_rdata_q   <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            err_q       <= err_d;
            starve_q    <= starve_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Next-state logic; RESP always returns to IDLE so req is never
    // re-sampled while the requester is still seeing its done pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (w_grant_i || w_grant_d) begin
                    state_d = w_misal ? c_st_resp : c_st_access;
                end
            end
            c_st_access: state_d = c_st_resp;
            c_st_resp:   state_d = c_st_idle;
            default:     state_d = c_st_idle;
        endcase
    end

    // Datapath / registered-output next values
    always_comb begin
        owner_d     = owner_q;
        err_d       = err_q;
        starve_d    = starve_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            c_st_idle: begin
                if (w_grant_i || w_grant_d) begin
                    owner_d = w_grant_d;
                    err_d   = w_misal;
                    if (w_grant_d && i_req) begin
                        starve_d = (starve_q < c_limit) ? (starve_q + 4'd1) : c_limit;
                    end else begin
                        starve_d = 4'd0;
                    end
                    // A rejected request leaves the memory bus untouched.
                    if (!w_misal) begin
                        mem_addr_d  = w_sel_addr;
                        mem_we_d    = w_grant_d && d_we;
                        mem_wdata_d = w_grant_d ? d_wdata : 32'd0;
                    end
                end
            end
            c_st_access: begin
                // mem_we_q still reflects the store flag of this access.
                if (!owner_q) begin
                    i_rdata_d = mem_rdata;
                end else if (!mem_we_q) begin
                    d_rdata_d = mem_rdata;
                end
                mem_we_d = 1'b0;
            end
            c_st_resp: err_d = 1'b0;
            default: ;
        endcase
    end

    // Output logic
    always_comb begin
        i_done    = (state_q == c_st_resp) && !owner_q;
        d_done    = (state_q == c_st_resp) && owner_q;
        i_err     = i_done && err_q;
        d_err     = d_done && err_q;
        busy      = (state_q != c_st_idle);
        owner     = owner_q;
        mem_addr  = mem_addr_q;
        mem_we    = mem_we_q;
        mem_wdata = mem_wdata_q;
        i_rdata   = i_rdata_q;
        d_rdata   = d_rdata_q;
    end

endmodule
`default_nettype wire
